demux_stream: RTL and testbench

Registered, packet-aware stream demultiplexer: one valid/ready input stream is steered to one of N valid/ready output channels. The destination is chosen by a select field on the first beat of a packet and held until the beat carrying `in_last`. It is the distributing counterpart of the mux family and sits at the point where a shared datapath fans out to per-unit consumers. Packets with an out-of-range select are consumed and dropped, with an error pulse.

---
 rtl/demux_pkg.sv | 11 +
 rtl/stream_slot.sv | 35 +++
 rtl/demux_stream.sv | 112 +++++++++++
 tb/tb_demux_stream.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types for the packet-aware stream demultiplexer.
package demux_pkg;

  // Packet-level state: no packet open, forwarding to a latched channel, or discarding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } statetype_t;

endpackage

// File: rtl/stream_slot.sv
// Single-entry valid/ready register holding one beat (data + last) for one channel.
module stream_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             out_ready,
  output logic             full,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             accept_c
);

  // Empty, or draining this cycle, so a new beat may land on the next edge.
  assign accept_c = ~full | out_ready;

  // Load wins over drain so a simultaneous drain+load keeps the slot full with new data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full     <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (load) begin
      full     <= 1'b1;
      out_data <= in_data;
      out_last <= in_last;
    end else if (full && out_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream.sv
// Registered, packet-aware demux: steers each packet to the channel chosen on its first beat.
module demux_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]    in_sel,
  input  logic               in_last,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_last,
  output logic               err,
  output logic               busy
);

  statetype_t      state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] dest;
  logic            sel_ok;
  logic            slot_rdy;
  logic            fwd;
  logic            err_d;
  logic            busy_d;
  logic [N-1:0]    accept;
  logic [N-1:0]    load;

  // State, latched destination and the registered err/busy flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err     <= err_d;
      busy    <= busy_d;
    end
  end

  // Next state, destination decode and in_ready; in_ready never looks at in_valid.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    err_d    = 1'b0;
    in_ready = 1'b0;
    fwd      = 1'b0;
    sel_ok   = (32'(in_sel) < N);
    dest     = (state_q == FWD) ? sel_q : in_sel;
    slot_rdy = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (dest == SELW'(i)) slot_rdy = accept[i];
    end
    case (state_q)
      IDLE: begin
        if (sel_ok) begin
          in_ready = slot_rdy;
          fwd      = 1'b1;
          if (in_valid && slot_rdy && !in_last) begin
            state_d = FWD;
            sel_d   = in_sel;
          end
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            err_d = 1'b1;
            if (!in_last) state_d = DROP;
          end
        end
      end
      FWD: begin
        in_ready = slot_rdy;
        fwd      = 1'b1;
        if (in_valid && slot_rdy && in_last) state_d = IDLE;
      end
      DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // One output slot per channel; only the addressed slot loads an accepted forwarded beat.
  for (genvar i = 0; i < N; i++) begin : g_slot
    assign load[i] = in_valid & in_ready & fwd & (dest == SELW'(i));

    stream_slot #(.WIDTH(WIDTH)) u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (load[i]),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_ready(out_ready[i]),
      .full     (out_valid[i]),
      .out_data (out_data[i*WIDTH +: WIDTH]),
      .out_last (out_last[i]),
      .accept_c (accept[i])
    );
  end

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench: a 4-channel and a 3-channel demux checked against a queue-based packet model.
module tb_demux_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [1:0]       in_valid, in_last, in_ready, err, busy;
  logic [1:0][1:0]  in_sel;
  logic [1:0][7:0]  in_data;
  logic [1:0][3:0]  out_ready, out_valid, out_last;
  logic [1:0][31:0] out_data;

  demux_stream #(.WIDTH(8), .N(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_sel(in_sel[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .err(err[0]), .busy(busy[0])
  );

  demux_stream #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_sel(in_sel[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1][2:0]), .out_ready(out_ready[1][2:0]),
    .out_data(out_data[1][23:0]), .out_last(out_last[1][2:0]),
    .err(err[1]), .busy(busy[1])
  );

  assign out_valid[1][3]      = 1'b0;
  assign out_last[1][3]       = 1'b0;
  assign out_data[1][31:24]   = '0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: per-channel queue of beats accepted but not yet taken by the consumer.
  logic [8:0] mq[8][$];
  bit  mopen[2], mdrop[2], merr[2], fired[2];
  int  mcur[2];
  int  nch[2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_rdy(int k);
    int s;
    if (mopen[k] && mdrop[k]) return 1'b1;
    s = mopen[k] ? mcur[k] : int'(in_sel[k]);
    if (s >= nch[k]) return 1'b1;
    return (mq[k*4+s].size() == 0) || out_ready[k][s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mq[i].delete();
    for (int k = 0; k < 2; k++) begin
      mopen[k] = 1'b0; mdrop[k] = 1'b0; merr[k] = 1'b0; mcur[k] = 0;
    end
  endtask

  // One clock: check outputs against the model, advance the model, then move to the next negedge.
  task automatic cycle();
    bit r[2];
    #1;
    if (!reset_n) model_reset();
    for (int k = 0; k < 2; k++) begin
      r[k] = exp_rdy(k);
      chk($sformatf("in_ready%0d", k), 32'(in_ready[k]), 32'(r[k]));
      chk($sformatf("err%0d", k), 32'(err[k]), 32'(merr[k]));
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(mopen[k]));
      for (int ch = 0; ch < nch[k]; ch++) begin
        int j;
        bit has;
        j   = k*4 + ch;
        has = (mq[j].size() != 0);
        chk($sformatf("valid%0d_%0d", k, ch), 32'(out_valid[k][ch]), 32'(has));
        if (has) begin
          chk($sformatf("data%0d_%0d", k, ch), 32'(out_data[k][ch*8 +: 8]), 32'(mq[j][0][7:0]));
          chk($sformatf("last%0d_%0d", k, ch), 32'(out_last[k][ch]), 32'(mq[j][0][8]));
        end
        if (!reset_n) begin
          chk($sformatf("rstdata%0d_%0d", k, ch), 32'(out_data[k][ch*8 +: 8]), 32'd0);
          chk($sformatf("rstlast%0d_%0d", k, ch), 32'(out_last[k][ch]), 32'd0);
        end
      end
    end
    fired[0] = 1'b0;
    fired[1] = 1'b0;
    if (reset_n) begin
      for (int k = 0; k < 2; k++) begin
        merr[k] = 1'b0;
        for (int ch = 0; ch < nch[k]; ch++)
          if (mq[k*4+ch].size() != 0 && out_ready[k][ch]) void'(mq[k*4+ch].pop_front());
        if (in_valid[k] && r[k]) begin
          int s;
          fired[k] = 1'b1;
          if (!mopen[k]) begin
            s = int'(in_sel[k]);
            if (s < nch[k]) begin
              mq[k*4+s].push_back({in_last[k], in_data[k]});
              if (!in_last[k]) begin mopen[k] = 1'b1; mdrop[k] = 1'b0; mcur[k] = s; end
            end else begin
              merr[k] = 1'b1;
              if (!in_last[k]) begin mopen[k] = 1'b1; mdrop[k] = 1'b1; end
            end
          end else begin
            if (!mdrop[k]) mq[k*4+mcur[k]].push_back({in_last[k], in_data[k]});
            if (in_last[k]) mopen[k] = 1'b0;
          end
        end
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one beat on instance k and hold it until accepted (bounded).
  task automatic send(int k, int sel, logic [7:0] d, bit last);
    in_valid[k] = 1'b1;
    in_sel[k]   = 2'(sel);
    in_data[k]  = d;
    in_last[k]  = last;
    for (int t = 0; t < 64; t++) begin
      cycle();
      if (fired[k]) break;
    end
    if (!fired[k]) chk($sformatf("send_timeout%0d", k), 32'(fired[k]), 32'd1);
    in_valid[k] = 1'b0;
  endtask

  task automatic idle(int n);
    in_valid = '0;
    for (int t = 0; t < n; t++) cycle();
  endtask

  initial begin
    int c0;
    nch[0] = 4;
    nch[1] = 3;
    model_reset();

    // Reset held with random inputs.
    reset_n   = 1'b0;
    in_valid  = 2'($urandom);
    in_last   = 2'($urandom);
    in_sel    = 4'($urandom);
    in_data   = 16'($urandom);
    out_ready = 8'($urandom);
    @(negedge clk);
    for (int t = 0; t < 3; t++) begin
      in_valid = 2'($urandom); in_sel = 4'($urandom); out_ready = 8'($urandom);
      cycle();
    end
    reset_n   = 1'b1;
    in_valid  = '0;
    out_ready = 8'hFF;
    cycle();

    // Single-beat packet never opens a packet.
    send(0, 2, 8'hA5, 1'b1);
    chk("single_valid", 32'(out_valid[0]), 32'h4);
    chk("single_data", 32'(out_data[0][23:16]), 32'hA5);
    chk("single_last", 32'(out_last[0][2]), 32'd1);
    idle(2);

    // Destination locked for the whole packet despite a changing in_sel.
    send(0, 1, 8'h01, 1'b0);
    for (int b = 2; b <= 4; b++) send(0, int'($urandom_range(0, 3)), 8'(b), b == 4);
    chk("lock_busy", 32'(busy[0]), 32'd0);
    idle(3);

    // Backpressure on channel 3: one beat buffered, then the input stalls.
    out_ready[0][3] = 1'b0;
    send(0, 3, 8'h30, 1'b0);
    in_valid[0] = 1'b1; in_sel[0] = 2'd0; in_data[0] = 8'h31; in_last[0] = 1'b1;
    for (int t = 0; t < 4; t++) cycle();
    chk("bp_stall_ready", 32'(in_ready[0]), 32'd0);
    chk("bp_hold_data", 32'(out_data[0][31:24]), 32'h30);
    out_ready[0][3] = 1'b1;
    send(0, 0, 8'h31, 1'b1);
    send(0, 0, 8'h0C, 1'b1);
    idle(3);

    // Simultaneous drain and load: three beats in three cycles.
    c0 = cyc;
    send(0, 0, 8'hD1, 1'b0);
    send(0, 2, 8'hD2, 1'b0);
    send(0, 3, 8'hD3, 1'b1);
    chk("dl_cycles", 32'(cyc - c0), 32'd3);
    idle(3);

    // Out-of-range select on the 3-channel instance is dropped with one err pulse.
    c0 = cyc;
    send(1, 3, 8'hE0, 1'b0);
    send(1, 1, 8'hE1, 1'b1);
    chk("drop_cycles", 32'(cyc - c0), 32'd2);
    chk("drop_err", 32'(err[1]), 32'd0);
    send(1, 0, 8'h11, 1'b1);
    chk("after_drop_valid", 32'(out_valid[1][2:0]), 32'h1);
    idle(3);

    // Reset in the middle of a packet abandons it.
    send(0, 1, 8'h41, 1'b0);
    send(0, 1, 8'h42, 1'b0);
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();
    send(0, 2, 8'h77, 1'b1);
    chk("rst_route", 32'(out_valid[0]), 32'h4);
    idle(2);

    // Randomised traffic on both instances, with the occasional reset.
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k] = ($urandom_range(0, 9) < 7);
        in_sel[k]   = 2'($urandom);
        in_data[k]  = 8'($urandom);
        in_last[k]  = ($urandom_range(0, 2) == 0);
        for (int ch = 0; ch < 4; ch++) out_ready[k][ch] = ($urandom_range(0, 3) != 0);
      end
      reset_n = ($urandom_range(0, 399) != 0);
      cycle();
    end
    reset_n = 1'b1;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
